// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue: synchronous FIFO of {instr, pc} entries, flush wins over push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned PW = $clog2(QDEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [PW:0]  count
);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  fetch_entry_t  mem_q [QDEPTH];

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a flushed push is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // The request gating upstream must keep a slot free for every outstanding response.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!reset) (push && !flush) |-> (count_q < (PW+1)'(QDEPTH))
  );

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns fetch PC, single-outstanding imem requests, redirect/flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        InstrValidF
);

  localparam int unsigned   PW         = $clog2(QDEPTH);
  localparam logic [PW+1:0] QDEPTH_W   = (PW+2)'(QDEPTH);
  localparam logic [31:0]   RESET_PC_W = RESET_PC & ~32'h3;

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pc_out_q, pc_out_d;
  logic          rsp_hit, req, enq, deq;
  logic [PW+1:0] credit;
  logic [PW:0]   q_count;
  fetch_entry_t  q_head, q_in;

  assign rsp_hit = (state_q == WAIT) && imem_rvalid;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; redirect dominates, a response caught by a redirect is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = WAIT;
      WAIT: begin
        if (PCSrcE)           state_d = imem_rvalid ? IDLE : DISCARD;
        else if (imem_rvalid) state_d = req ? WAIT : IDLE;
      end
      DISCARD: if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request gating counts the arriving response but not a same-cycle dequeue.
  always_comb begin
    credit = {1'b0, q_count} + {{(PW+1){1'b0}}, rsp_hit};
    req    = ((state_q == IDLE) || rsp_hit) && !PCSrcE && (credit < QDEPTH_W);
    enq    = rsp_hit && !PCSrcE;
    deq    = InstrValidF && !StallD && !PCSrcE;
  end

  // Next fetch PC and address of the request in flight.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_out_d   = pc_out_q;
    if (PCSrcE) begin
      fetch_pc_d = PCTargetE & ~32'h3;
    end else if (req) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      pc_out_d   = fetch_pc_q;
    end
  end

  // PC registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC_W;
      pc_out_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_out_q   <= pc_out_d;
    end
  end

  assign q_in = '{instr: imem_rdata, pc: pc_out_q};

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (enq),
    .pop       (deq),
    .flush     (PCSrcE),
    .push_data (q_in),
    .head      (q_head),
    .count     (q_count)
  );

  // The request is masked while reset is held so it reads 0 in the reset state.
  assign imem_req    = reset & req;
  assign imem_addr   = fetch_pc_q;
  assign InstrValidF = (q_count != '0);
  assign InstrF      = InstrValidF ? q_head.instr : '0;
  assign PCF         = InstrValidF ? q_head.pc : '0;
  assign PCPlus4F    = InstrValidF ? (q_head.pc + 32'd4) : '0;

endmodule
